ddc_accumulator: RTL and testbench

- Integrate-and-dump stage directly downstream of the DDC core.
- Consumes the DDC's 64-bit I/Q output (29 valid bits each, sign-extended to 32) with its valid strobe.
- Sums a programmable number of consecutive samples per frame and emits one 2x48-bit I/Q result per frame on an AXI-Stream-style master with backpressure.
- Provides a frame counter and a sticky overflow flag for the DAQ readout.

---
 rtl/ddc_daq_pkg.sv | 18 +
 rtl/ddc_acc_fifo2.sv | 55 +++++
 rtl/ddc_accumulator.sv | 113 +++++++++++
 tb/tb_ddc_accumulator.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ddc_daq_pkg.sv
// Shared constants and result payload for the DDC integrate-and-dump readout path.
package ddc_daq_pkg;

    localparam int unsigned DDC_IN_W   = 29;
    localparam int unsigned LANE_I_OFS = 0;
    localparam int unsigned LANE_Q_OFS = 32;

    localparam int unsigned ACC_W_DEF  = 48;
    localparam int unsigned LEN_W_DEF  = 16;
    localparam int unsigned FCNT_W_DEF = 32;

    typedef struct packed {
        logic signed [ACC_W_DEF-1:0] q;
        logic signed [ACC_W_DEF-1:0] i;
        logic [FCNT_W_DEF-1:0]       frame;
    } acc_result_t;

endpackage

// File: rtl/ddc_acc_fifo2.sv
// Two-entry registered output FIFO; head entry drives the stream outputs directly.
module ddc_acc_fifo2 #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    output logic          drop_c,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
);

    logic          v0_q, v1_q;
    logic [DW-1:0] d0_q, d1_q;
    logic          pop_c;

    assign pop_c   = v0_q && m_ready;
    // Only a push into a full FIFO without a simultaneous pop is lost.
    assign drop_c  = push && v1_q && !pop_c;
    assign m_valid = v0_q;
    assign m_data  = d0_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            d0_q <= '0;
            d1_q <= '0;
        end else if (pop_c) begin
            if (push) begin
                if (v1_q) begin
                    d0_q <= d1_q;
                    d1_q <= din;
                end else begin
                    d0_q <= din;
                end
            end else begin
                d0_q <= d1_q;
                v0_q <= v1_q;
                v1_q <= 1'b0;
            end
        end else if (push) begin
            if (!v0_q) begin
                d0_q <= din;
                v0_q <= 1'b1;
            end else if (!v1_q) begin
                d1_q <= din;
                v1_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddc_accumulator.sv
// Integrate-and-dump of DDC I/Q samples into per-frame sums on a valid/ready stream.
module ddc_accumulator
    import ddc_daq_pkg::*;
#(
    parameter int unsigned IN_W   = DDC_IN_W,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF,
    parameter int unsigned FCNT_W = FCNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [LEN_W-1:0]     acc_len,
    input  logic                 s_valid,
    input  logic [63:0]          s_data,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [2*ACC_W-1:0]   m_tdata,
    output logic [FCNT_W-1:0]    m_tuser,
    output logic                 overflow,
    input  logic                 ovf_clr
);

    localparam int unsigned DW = 2*ACC_W + FCNT_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    logic [0:0]               state_q, state_d;
    logic [LEN_W-1:0]         count_q, len_q;
    logic [LEN_W-1:0]         len_sel_c, len_cur_c;
    logic signed [ACC_W-1:0]  acc_i_q, acc_q_q;
    logic signed [ACC_W-1:0]  smp_i_c, smp_q_c, sum_i_c, sum_q_c;
    logic [FCNT_W-1:0]        frame_q;
    logic                     take_c, first_c, last_c, push_c, drop_c;
    logic                     ovf_q;
    logic [DW-1:0]            fifo_data;
    logic                     data_unused_c;

    // Upper bits of each lane carry only sign extension and are ignored.
    assign data_unused_c = ^s_data;

    assign smp_i_c = {{(ACC_W-IN_W){s_data[LANE_I_OFS+IN_W-1]}}, s_data[LANE_I_OFS +: IN_W]};
    assign smp_q_c = {{(ACC_W-IN_W){s_data[LANE_Q_OFS+IN_W-1]}}, s_data[LANE_Q_OFS +: IN_W]};

    // First sample of a frame starts from zero, so frames run back to back.
    assign sum_i_c = (first_c ? ACC_W'(0) : acc_i_q) + smp_i_c;
    assign sum_q_c = (first_c ? ACC_W'(0) : acc_q_q) + smp_q_c;

    always_comb begin
        state_d   = state_q;
        take_c    = en && s_valid;
        first_c   = (state_q == ST_IDLE) || (count_q == '0);
        len_sel_c = (acc_len == '0) ? LEN_W'(1) : acc_len;
        len_cur_c = first_c ? len_sel_c : len_q;
        last_c    = (count_q == (len_cur_c - LEN_W'(1)));
        push_c    = take_c && last_c;
        case (state_q)
            ST_IDLE:  if (en)  state_d = ST_ACCUM;
            ST_ACCUM: if (!en) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            len_q   <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
            frame_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (!en) begin
                count_q <= '0;
            end else if (take_c) begin
                acc_i_q <= sum_i_c;
                acc_q_q <= sum_q_c;
                if (first_c) len_q <= len_sel_c;
                count_q <= last_c ? LEN_W'(0) : count_q + LEN_W'(1);
            end
            // Frame index advances even on a dropped dump so the gap shows in m_tuser.
            if (push_c) frame_q <= frame_q + FCNT_W'(1);
            if (drop_c)       ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    ddc_acc_fifo2 #(
        .DW (DW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_c),
        .din     ({frame_q, sum_q_c, sum_i_c}),
        .drop_c  (drop_c),
        .m_valid (m_tvalid),
        .m_ready (m_tready),
        .m_data  (fifo_data)
    );

    assign {m_tuser, m_tdata} = fifo_data;
    assign overflow           = ovf_q;

endmodule

// File: tb/tb_ddc_accumulator.sv
// Scoreboard bench for ddc_accumulator: expected frame sums queued at drive time, checked on transfer.
module tb_ddc_accumulator;
    import ddc_daq_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [15:0]  acc_len;
    logic         s_valid;
    logic [63:0]  s_data;
    logic         m_tvalid;
    logic         m_tready;
    logic [95:0]  m_tdata;
    logic [31:0]  m_tuser;
    logic         overflow;
    logic         ovf_clr;

    int checks;
    int failures;
    acc_result_t sb[$];

    ddc_accumulator dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .acc_len  (acc_len),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tuser  (m_tuser),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input longint ei, input longint eq, input int fr);
        acc_result_t e;
        e.i     = 48'(ei);
        e.q     = 48'(eq);
        e.frame = 32'(fr);
        sb.push_back(e);
    endtask

    // Drives one sample for one cycle; junk in the unused lane bits.
    task automatic sample(input int i, input int q);
        logic [31:0] iv, qv;
        iv = i;
        qv = q;
        s_valid = 1'b1;
        s_data  = {3'b101, qv[28:0], 3'b010, iv[28:0]};
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 50; n++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        check({tag, "_drain"}, 128'(sb.size()), 128'(0));
        @(posedge clk); #1;
        check({tag, "_empty"}, 128'(m_tvalid), 128'(0));
    endtask

    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 128'(1), 128'(0));
            end else begin
                acc_result_t e;
                e = sb.pop_front();
                check("tdata", 128'(m_tdata), 128'({e.q, e.i}));
                check("tuser", 128'(m_tuser), 128'(e.frame));
            end
        end
    end

    initial begin
        longint ei, eq;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        acc_len  = 16'd4;
        s_valid  = 1'b0;
        s_data   = '0;
        m_tready = 1'b1;
        ovf_clr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 128'(m_tvalid), 128'(0));
        check("rst_tdata", 128'(m_tdata), 128'(0));
        check("rst_tuser", 128'(m_tuser), 128'(0));
        check("rst_ovf", 128'(overflow), 128'(0));
        rst_n = 1'b1;

        // Basic frame of 4 with latency check
        en = 1'b1;
        sample(1, -1);
        sample(2, -1);
        sample(3, -1);
        check("t1_pre_valid", 128'(m_tvalid), 128'(0));
        sample(4, -1);
        push_exp(10, -4, 0);
        check("t1_latency", 128'(m_tvalid), 128'(1));
        drain("t1");

        // Length 1, back to back, then length 0 treated as 1
        do_reset();
        acc_len = 16'd1;
        for (int k = 0; k < 5; k++) begin
            sample(k, 0);
            push_exp(k, 0, k);
            check("t2_cont_valid", 128'(m_tvalid), 128'(1));
        end
        acc_len = 16'd0;
        sample(9, -3);
        push_exp(9, -3, 5);
        drain("t2");

        // Backpressure, overflow drop and frame gap
        do_reset();
        m_tready = 1'b0;
        acc_len  = 16'd2;
        for (int k = 0; k < 6; k++) sample(k + 1, k);
        push_exp(3, 1, 0);
        push_exp(7, 5, 1);
        check("t3_ovf_set", 128'(overflow), 128'(1));
        for (int k = 0; k < 3; k++) begin
            check("t3_hold_data", 128'(m_tdata), 128'({sb[0].q, sb[0].i}));
            check("t3_hold_user", 128'(m_tuser), 128'(sb[0].frame));
            check("t3_hold_valid", 128'(m_tvalid), 128'(1));
            @(posedge clk); #1;
        end
        m_tready = 1'b1;
        drain("t3a");
        sample(100, -5);
        sample(100, -5);
        push_exp(200, -10, 3);
        drain("t3b");
        check("t3_ovf_sticky", 128'(overflow), 128'(1));
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check("t3_ovf_clr", 128'(overflow), 128'(0));

        // Abort via en, len change mid-frame applies next frame
        do_reset();
        acc_len = 16'd3;
        sample(5, 1);
        sample(5, 1);
        en = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
        sample(7, 0);
        acc_len = 16'd1;
        sample(7, 0);
        sample(7, 0);
        push_exp(21, 0, 0);
        sample(4, 2);
        push_exp(4, 2, 1);
        drain("t4");

        // Extreme values over the longest frame
        do_reset();
        acc_len = 16'hFFFF;
        for (int k = 0; k < 65535; k++) sample(-(1 << 28), (1 << 28) - 1);
        ei = -65535 * (longint'(1) << 28);
        eq = 65535 * ((longint'(1) << 28) - 1);
        push_exp(ei, eq, 0);
        check("t5_latency", 128'(m_tvalid), 128'(1));
        drain("t5");

        // Reset with full FIFO, overflow set and a half frame
        do_reset();
        m_tready = 1'b0;
        acc_len  = 16'd2;
        for (int k = 0; k < 6; k++) sample(1, 1);
        sample(50, 50);
        check("t6_pre_ovf", 128'(overflow), 128'(1));
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t6_rst_tvalid", 128'(m_tvalid), 128'(0));
        check("t6_rst_ovf", 128'(overflow), 128'(0));
        check("t6_rst_tuser", 128'(m_tuser), 128'(0));
        check("t6_rst_tdata", 128'(m_tdata), 128'(0));
        rst_n = 1'b1;
        sb.delete();
        m_tready = 1'b1;
        sample(2, -2);
        sample(3, -3);
        push_exp(5, -5, 0);
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
